// File: rtl/dbg_cmd_sysclk_multi_if.sv
// Handshake/status bundle between the TCK-side debug logic, the command
// consumers and dbg_cmd_sysclk_multi.
interface dbg_cmd_sysclk_multi_if #(
    parameter int SR_W = 38,
    parameter int IR_W = 2,
    parameter int N_CH = 4
);
    logic [IR_W-1:0] ir_in;
    logic [SR_W-1:0] sr;
    logic            vs_uir;
    logic            vs_udr;
    logic [N_CH-1:0] action_ack;
    logic            clear_err;
    logic [SR_W-1:0] jdo;
    logic [N_CH-1:0] take_action;
    logic [N_CH-1:0] take_no_action;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] overrun;
    logic [N_CH-1:0] timeout;
    logic            bad_ir;

    modport master (
        output ir_in, sr, vs_uir, vs_udr, action_ack, clear_err,
        input  jdo, take_action, take_no_action, busy, overrun, timeout, bad_ir
    );

    modport slave (
        input  ir_in, sr, vs_uir, vs_udr, action_ack, clear_err,
        output jdo, take_action, take_no_action, busy, overrun, timeout, bad_ir
    );
endinterface

// File: rtl/dbg_cmd_sysclk_multi.sv
// System-clock command stage for the Nios II debug slave: syncs JTAG update strobes,
// captures jdo and issues per-channel action pulses. Ack timeout: DBG_CMD_ACK_TIMEOUT_EN.
module dbg_cmd_sysclk_multi #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    dbg_cmd_sysclk_multi_if.slave bus
);
    localparam int unsigned NCH = N_CH;
    localparam int unsigned SL  = SYNC_STAGES - 1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_e;

    logic [SYNC_STAGES-1:0] r_uir_sync, r_udr_sync, r_vld;
    logic                   r_uir_hist, r_udr_hist, r_uir_arm, r_udr_arm, r_udr_e;
    logic [IR_W-1:0]        r_ir_q;
    logic                   w_uir_e, w_udr_e;

    ch_state_e              r_state [N_CH];
    ch_state_e              w_state_nxt [N_CH];
    logic [NCH-1:0]         w_issue, w_noact, w_ovr_set, w_busy;
    logic                   w_bad_set;

    logic [SR_W-1:0]        r_jdo;
    logic [NCH-1:0]         r_take_act, r_take_no, r_ovr;
    logic                   r_bad;

    // A level already high when reset releases must not look like an edge: the
    // arm flag only sets once a genuinely sampled low has reached the chain end.
    assign w_uir_e = r_uir_sync[SL] & ~r_uir_hist & r_uir_arm;
    assign w_udr_e = r_udr_sync[SL] & ~r_udr_hist & r_udr_arm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_uir_sync <= '0;
            r_udr_sync <= '0;
            r_vld      <= '0;
            r_uir_hist <= 1'b0;
            r_udr_hist <= 1'b0;
            r_uir_arm  <= 1'b0;
            r_udr_arm  <= 1'b0;
            r_udr_e    <= 1'b0;
            r_ir_q     <= '0;
        end else begin
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
            r_vld      <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_uir_hist <= r_uir_sync[SL];
            r_udr_hist <= r_udr_sync[SL];
            r_uir_arm  <= r_uir_arm | (r_vld[SL] & ~r_uir_sync[SL]);
            r_udr_arm  <= r_udr_arm | (r_vld[SL] & ~r_udr_sync[SL]);
            r_udr_e    <= w_udr_e;
            if (w_uir_e) begin
                r_ir_q <= bus.ir_in;
            end
        end
    end

`ifdef DBG_CMD_ACK_TIMEOUT_EN
    logic [15:0]    r_cnt [N_CH];
    logic [NCH-1:0] r_timeout;
    logic [NCH-1:0] w_to_set;
`endif

    // IR capture runs one cycle ahead of the registered DR edge, so a
    // simultaneous IR/DR update decodes against the new IR.
    always_comb begin
        w_issue   = '0;
        w_noact   = '0;
        w_ovr_set = '0;
        w_bad_set = 1'b0;
`ifdef DBG_CMD_ACK_TIMEOUT_EN
        w_to_set  = '0;
`endif
        for (int unsigned c = 0; c < NCH; c++) begin
            w_state_nxt[c] = r_state[c];
        end
        if (r_udr_e) begin
            if (32'(r_ir_q) >= NCH) begin
                w_bad_set = 1'b1;
            end else begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    if (r_ir_q == IR_W'(c)) begin
                        if (!bus.sr[SR_W-1])            w_noact[c]   = 1'b1;
                        else if (r_state[c] == CH_IDLE) w_issue[c]   = 1'b1;
                        else                            w_ovr_set[c] = 1'b1;
                    end
                end
            end
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            if (w_issue[c]) begin
                w_state_nxt[c] = CH_BUSY;
            end else if (r_state[c] == CH_BUSY && bus.action_ack[c]) begin
                w_state_nxt[c] = CH_IDLE;
            end
`ifdef DBG_CMD_ACK_TIMEOUT_EN
            else if (r_state[c] == CH_BUSY && r_cnt[c] == 16'(TIMEOUT_CYC - 1)) begin
                w_state_nxt[c] = CH_IDLE;
                w_to_set[c]    = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_state[c] <= CH_IDLE;
            end
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_state[c] <= w_state_nxt[c];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jdo      <= '0;
            r_take_act <= '0;
            r_take_no  <= '0;
            r_ovr      <= '0;
            r_bad      <= 1'b0;
        end else begin
            r_take_act <= w_issue;
            r_take_no  <= w_noact;
            if (r_udr_e) begin
                r_jdo <= bus.sr;
            end
            r_ovr <= (r_ovr & ~{NCH{bus.clear_err}}) | w_ovr_set;
            r_bad <= (r_bad & ~bus.clear_err) | w_bad_set;
        end
    end

`ifdef DBG_CMD_ACK_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_cnt[c] <= '0;
            end
            r_timeout <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (r_state[c] == CH_IDLE) r_cnt[c] <= '0;
                else                       r_cnt[c] <= r_cnt[c] + 16'd1;
            end
            r_timeout <= (r_timeout & ~{NCH{bus.clear_err}}) | w_to_set;
        end
    end
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = '0;
`endif

    always_comb begin
        w_busy = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_busy[c] = (r_state[c] == CH_BUSY);
        end
    end

    assign bus.busy           = w_busy;
    assign bus.jdo            = r_jdo;
    assign bus.take_action    = r_take_act;
    assign bus.take_no_action = r_take_no;
    assign bus.overrun        = r_ovr;
    assign bus.bad_ir         = r_bad;
endmodule

// File: tb/tb_dbg_cmd_sysclk_multi.sv
// Bench for dbg_cmd_sysclk_multi: directed table, corner sequences and a
// randomized run against a transaction-level channel model.
`timescale 1ns/1ps
module tb_dbg_cmd_sysclk_multi;
    localparam int SR_W = 38;
    localparam int IR_W = 2;
    localparam int N_CH = 4;
`ifdef DBG_CMD_ACK_TIMEOUT_EN
    localparam int TO_MAIN = 65535;
`else
    localparam int TO_MAIN = 255;
`endif
    localparam int TO_SMALL = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dbg_cmd_sysclk_multi_if #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(N_CH)) bus_if ();
    dbg_cmd_sysclk_multi_if #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(3))    bus3 ();

    assign bus3.ir_in      = bus_if.ir_in;
    assign bus3.sr         = bus_if.sr;
    assign bus3.vs_uir     = bus_if.vs_uir;
    assign bus3.vs_udr     = bus_if.vs_udr;
    assign bus3.action_ack = bus_if.action_ack[2:0];
    assign bus3.clear_err  = bus_if.clear_err;

    dbg_cmd_sysclk_multi #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(N_CH), .SYNC_STAGES(2),
                           .TIMEOUT_CYC(TO_MAIN)) dut (
        .clk(clk), .reset(reset), .bus(bus_if));

    dbg_cmd_sysclk_multi #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(3), .SYNC_STAGES(2),
                           .TIMEOUT_CYC(TO_SMALL)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3));

    int n_err = 0;
    int n_checks = 0;

    typedef struct {
        logic [1:0]  ir;
        logic        flag;
        logic [36:0] data;
        logic [3:0]  ack;
        int          ack_at;
        int          clr_at;
        logic [3:0]  e_act;
        logic [3:0]  e_noact;
        logic [3:0]  e_busy;
        logic [3:0]  e_ovr;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [1:0] ir);
        bus_if.ir_in  = ir;
        bus_if.vs_uir = 1'b1;
        repeat (5) tick();
        bus_if.vs_uir = 1'b0;
        repeat (5) tick();
    endtask

    task automatic ack_pulse(input logic [3:0] m);
        bus_if.action_ack = m;
        tick();
        bus_if.action_ack = '0;
    endtask

    task automatic clr_pulse();
        bus_if.clear_err = 1'b1;
        tick();
        bus_if.clear_err = 1'b0;
    endtask

    // One DR update; offset 0 is the first clk edge that sees vs_udr high.
    task automatic udr_update(input logic [37:0] s, input logic uir_too,
                              input logic [3:0] ack, input int ack_at, input int clr_at,
                              output logic [3:0] act, output logic [3:0] noact,
                              output int npulse, output int first_i, output logic [2:0] act3);
        act = '0; noact = '0; npulse = 0; first_i = -1; act3 = '0;
        bus_if.sr     = s;
        bus_if.vs_udr = 1'b1;
        if (uir_too) bus_if.vs_uir = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if ((bus_if.take_action | bus_if.take_no_action) != '0 && first_i < 0) first_i = i;
            npulse += $countones(bus_if.take_action) + $countones(bus_if.take_no_action);
            act   |= bus_if.take_action;
            noact |= bus_if.take_no_action;
            act3  |= bus3.take_action;
            bus_if.action_ack = (i == ack_at) ? ack : 4'b0000;
            bus_if.clear_err  = (i == clr_at);
            if (i == 5) begin
                bus_if.vs_udr = 1'b0;
                bus_if.vs_uir = 1'b0;
            end
        end
    endtask

    task automatic check_update(input string tag, input logic [37:0] s,
                                input logic [3:0] e_act, input logic [3:0] e_noact,
                                input logic [3:0] e_busy, input logic [3:0] e_ovr,
                                input logic [3:0] act, input logic [3:0] noact,
                                input int npulse, input int first_i);
        int e_n;
        e_n = ((e_act | e_noact) != '0) ? 1 : 0;
        check({tag, " act"}, 64'(act), 64'(e_act));
        check({tag, " noact"}, 64'(noact), 64'(e_noact));
        check({tag, " npulse"}, 64'(npulse), 64'(e_n));
        check({tag, " latency"}, 64'(first_i), (e_n == 1) ? 64'(3) : 64'(-1));
        check({tag, " jdo"}, 64'(bus_if.jdo), 64'(s));
        check({tag, " busy"}, 64'(bus_if.busy), 64'(e_busy));
        check({tag, " overrun"}, 64'(bus_if.overrun), 64'(e_ovr));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  act, noact, m_busy, m_ovr, e_act, e_noact, mask;
        logic [2:0]  act3;
        logic [37:0] s;
        logic [1:0]  ir;
        logic        flag;
        int          np, fi, quiet;

        tbl[0] = '{2'd1, 1'b1, 37'h5A5A5A5A5, 4'h0, -1, -1, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
        tbl[1] = '{2'd2, 1'b1, 37'h0000000123, 4'h0, -1, -1, 4'b0100, 4'b0000, 4'b0110, 4'b0000};
        tbl[2] = '{2'd2, 1'b1, 37'h0000000456, 4'h0, -1, -1, 4'b0000, 4'b0000, 4'b0110, 4'b0100};
        tbl[3] = '{2'd0, 1'b0, 37'h0000000077, 4'h0, -1, -1, 4'b0000, 4'b0001, 4'b0110, 4'b0100};
        tbl[4] = '{2'd0, 1'b1, 37'h0000000001, 4'h0, -1, -1, 4'b0001, 4'b0000, 4'b0111, 4'b0100};
        tbl[5] = '{2'd0, 1'b0, 37'h1FFFFFFFFF, 4'h0, -1, -1, 4'b0000, 4'b0001, 4'b0111, 4'b0100};
        tbl[6] = '{2'd3, 1'b1, 37'h00000003C3, 4'h8,  2, -1, 4'b1000, 4'b0000, 4'b1111, 4'b0100};
        tbl[7] = '{2'd3, 1'b1, 37'h0000000000, 4'h0, -1,  2, 4'b0000, 4'b0000, 4'b1111, 4'b1000};

        bus_if.ir_in = '0; bus_if.sr = '0; bus_if.vs_uir = 1'b0; bus_if.vs_udr = 1'b0;
        bus_if.action_ack = '0; bus_if.clear_err = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset jdo", 64'(bus_if.jdo), 64'(0));
        check("reset busy", 64'(bus_if.busy), 64'(0));
        check("reset pulses", 64'({bus_if.take_action, bus_if.take_no_action}), 64'(0));
        check("reset status", 64'({bus_if.overrun, bus_if.timeout, bus_if.bad_ir}), 64'(0));

        for (int i = 0; i < 8; i++) begin
            s = {tbl[i].flag, tbl[i].data};
            set_ir(tbl[i].ir);
            udr_update(s, 1'b0, tbl[i].ack, tbl[i].ack_at, tbl[i].clr_at, act, noact, np, fi, act3);
            check_update($sformatf("vec%0d", i), s, tbl[i].e_act, tbl[i].e_noact,
                         tbl[i].e_busy, tbl[i].e_ovr, act, noact, np, fi);
        end

        ack_pulse(4'b0010);
        check("ack clears busy", 64'(bus_if.busy), 64'(4'b1101));
        ack_pulse(4'b0010);
        check("ack idle ignored", 64'(bus_if.busy), 64'(4'b1101));
        clr_pulse();
        check("clear overrun", 64'(bus_if.overrun), 64'(0));
        check("n3 bad_ir cleared", 64'(bus3.bad_ir), 64'(0));
        ack_pulse(4'b1000);
        check("ack ch3", 64'(bus_if.busy), 64'(4'b0101));

        // IR and DR updates rising together: decode must use the new IR.
        set_ir(2'd1);
        bus_if.ir_in = 2'd3;
        s = {1'b1, 37'h15};
        udr_update(s, 1'b1, 4'h0, -1, -1, act, noact, np, fi, act3);
        check_update("simul", s, 4'b1000, 4'b0000, 4'b1101, 4'b0000, act, noact, np, fi);
        check("n3 simul no pulse", 64'(act3), 64'(0));
        check("n3 simul bad_ir", 64'(bus3.bad_ir), 64'(1));
        check("main bad_ir", 64'(bus_if.bad_ir), 64'(0));

        // Asynchronous reset while busy with vs_udr held high across release.
        bus_if.sr = {1'b1, 37'h99};
        bus_if.vs_udr = 1'b1;
        repeat (6) tick();
        check("pre-reset overrun", 64'(bus_if.overrun), 64'(4'b1000));
        #3 reset = 1'b1;
        #1;
        check("async rst busy", 64'(bus_if.busy), 64'(0));
        check("async rst jdo", 64'(bus_if.jdo), 64'(0));
        check("async rst status", 64'({bus_if.overrun, bus_if.bad_ir, bus3.bad_ir}), 64'(0));
        tick(); tick();
        reset = 1'b0;
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            quiet += $countones(bus_if.take_action) + $countones(bus_if.take_no_action);
        end
        check("no pulse after release", 64'(quiet), 64'(0));
        bus_if.vs_udr = 1'b0;
        repeat (5) tick();
        s = {1'b1, 37'h2A};
        udr_update(s, 1'b0, 4'h0, -1, -1, act, noact, np, fi, act3);
        check_update("post-reset", s, 4'b0001, 4'b0000, 4'b0001, 4'b0000, act, noact, np, fi);

        m_busy = 4'b0001;
        m_ovr  = 4'b0000;
        for (int n = 0; n < 40; n++) begin
            mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            if (mask != '0) begin
                ack_pulse(mask);
                m_busy = m_busy & ~mask;
                check($sformatf("rnd%0d ack busy", n), 64'(bus_if.busy), 64'(m_busy));
            end
            if ($urandom_range(0, 3) == 0) begin
                clr_pulse();
                m_ovr = '0;
            end
            ir   = 2'($urandom_range(0, 3));
            flag = ($urandom_range(0, 3) != 0);
            s    = {flag, 37'({$urandom, $urandom})};
            e_act = '0;
            e_noact = '0;
            if (!flag)              e_noact[ir] = 1'b1;
            else if (!m_busy[ir]) begin
                e_act[ir]  = 1'b1;
                m_busy[ir] = 1'b1;
            end else                m_ovr[ir]   = 1'b1;
            set_ir(ir);
            udr_update(s, 1'b0, 4'h0, -1, -1, act, noact, np, fi, act3);
            check_update($sformatf("rnd%0d", n), s, e_act, e_noact, m_busy, m_ovr, act, noact, np, fi);
        end
        check("rnd bad_ir", 64'(bus_if.bad_ir), 64'(0));

`ifdef DBG_CMD_ACK_TIMEOUT_EN
        begin
            int ta, bf;
            logic tflag;
            ta = -1; bf = -1; tflag = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            tick();
            set_ir(2'd0);
            bus_if.sr = {1'b1, 37'h0};
            bus_if.vs_udr = 1'b1;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (bus3.take_action[0] && ta < 0) ta = i;
                if (ta >= 0 && i > ta && bf < 0 && !bus3.busy[0]) begin
                    bf = i;
                    tflag = bus3.timeout[0];
                end
                if (i == 5) bus_if.vs_udr = 1'b0;
            end
            check("to take seen", 64'(ta), 64'(3));
            check("to busy fall delay", 64'(bf - ta), 64'(TO_SMALL));
            check("to sticky set", 64'(tflag), 64'(1));
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/dbg_cmd_sysclk_multi.md
# dbg_cmd_sysclk_multi

Parametrised system-clock command stage for the Nios II debug slave. Samples the asynchronous JTAG update strobes and shift-register image from the TCK-domain block and captures the command into `jdo`. Decodes the latched virtual IR into per-channel one-cycle `take_action` / `take_no_action` pulses. Unlike the fixed 2-bit/38-bit predecessor, it adds:

- configurable IR, data and channel widths;
- per-channel busy/acknowledge handshaking;
- overrun and illegal-IR status.

## Interface
Parameters:
- `SR_W`, 38: width of `sr` and `jdo`; bit `SR_W-1` is the action flag.
- `IR_W`, 2: virtual IR width.
- `N_CH`, 4: number of command channels, 1..2^IR_W.
- `SYNC_STAGES`, 2: synchronizer depth for `vs_udr` / `vs_uir`, minimum 2.
- `TIMEOUT_CYC`, 255: acknowledge timeout in clk cycles, 1..65535. Used only with `DBG_CMD_ACK_TIMEOUT_EN`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `ir_in`, input, IR_W: virtual IR from the TCK domain; stable while `vs_uir` is high.
- `sr`, input, SR_W: DR shift-register image; stable while `vs_udr` is high.
- `vs_uir`, input, 1: update-IR level, asynchronous to clk.
- `vs_udr`, input, 1: update-DR level, asynchronous to clk.
- `action_ack`, input, N_CH: per-channel completion; 1-cycle pulse.
- `clear_err`, input, 1: 1-cycle pulse; clears all sticky status.
- `jdo`, output, SR_W: captured command data.
- `take_action`, output, N_CH: 1-cycle pulse, flag set.
- `take_no_action`, output, N_CH: 1-cycle pulse, flag clear.
- `busy`, output, N_CH: channel awaiting ack.
- `overrun`, output, N_CH: sticky; action dropped because the channel was busy.
- `timeout`, output, N_CH: sticky; ack timeout expired.
- `bad_ir`, output, 1: sticky; update with `ir_q >= N_CH`.

## Operation
- **Synchronizers:** `vs_uir` and `vs_udr` each pass through a SYNC_STAGES flop chain plus one history flop. `uir_e` and `udr_e` are the rising edges of the synchronized levels.
- **IR capture:** on `uir_e`, `ir_q <= ir_in`.
- **DR capture:** on `udr_e`, `jdo <= sr` unconditionally. Then `c = ir_q`:
  - if `c >= N_CH`: no pulse; `bad_ir <= 1`.
  - else if `sr[SR_W-1] == 0`: `take_no_action[c]` pulses. This is independent of `busy`.
  - else if `busy[c] == 0`: `take_action[c]` pulses and `busy[c] <= 1`.
  - else: no pulse; `overrun[c] <= 1`.
- **Simultaneous `uir_e` and `udr_e`:** the IR update applies first, so decode uses the new `ir_in`.
- **Acknowledge:** `action_ack[c]` clears `busy[c]` on the next edge. Ack while not busy is ignored. Ack in the same cycle that `take_action[c]` is generated is ignored; `busy` is set.
- **Sticky clear:** `clear_err` clears `overrun`, `timeout` and `bad_ir`. If a set condition occurs in the same cycle, the set wins.
- **Channel state machine**, per channel, 2 states:
  - IDLE → BUSY on an issued action.
  - BUSY → IDLE on ack.
  - BUSY → IDLE on timeout, macro builds only.
- **Reset**, asserted at any time: all outputs, `ir_q`, synchronizer and history flops, and timeout counters go to 0. Pending commands and busy channels are discarded. A `vs_udr` level still high at reset release produces no edge until it falls and rises again.

## Timing
- Latency: an edge on `vs_udr` first sampled high at clk edge k gives a `take_*` pulse and `jdo` update at edge k+SYNC_STAGES+1. With defaults this is k+3.
- Pulses are exactly 1 cycle wide, regardless of how long `vs_udr` stays high.
- Minimum `vs_udr` high and low time is SYNC_STAGES+1 clk cycles. Shorter pulses may be missed; no pulse is ever duplicated.
- `busy` rises in the same cycle as `take_action` and falls 1 cycle after `action_ack`.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `DBG_CMD_ACK_TIMEOUT_EN` defined:
  - each channel has a 16-bit counter, loaded to 0 when entering BUSY and incremented each BUSY cycle;
  - when it reaches TIMEOUT_CYC, the channel goes `busy <= 0` and `timeout[c] <= 1`;
  - ack in the same cycle as expiry: ack wins, no timeout.
- Undefined: no counters; a channel stays busy until ack or reset, and `timeout` is tied to 0.

## Test plan
- IR=1, `sr[37]=1`, `sr[36:0]=0x5A5A5A5A5`:
  - `take_action[1]` is a single pulse 3 cycles after `vs_udr` rises, `jdo=0x25A5A5A5A5`, `busy=4'b0010`;
  - `action_ack[1]` → `busy=0` the next cycle.
- IR=2: two action updates with no ack:
  - first update pulses `take_action[2]`;
  - second gives no pulse, `overrun=4'b0100`, `jdo` updated;
  - `clear_err` → `overrun=0`.
- IR=0, `sr[37]=0`, while channel 0 is busy → `take_no_action[0]` pulses and `busy[0]` stays 1.
- `vs_uir` (IR=3) and `vs_udr` rise together with `sr[37]=1` → `take_action[3]` pulses, not the old channel. With `N_CH=3`: no pulse and `bad_ir=1`.
- Macro on, `TIMEOUT_CYC=10`, no ack → `busy[0]` falls and `timeout[0]` sets 10 cycles after `take_action[0]`.
- Macro on: reset asserted mid-busy → all outputs are 0 immediately (asynchronous), and no pulse after release while `vs_udr` stays high.
